// File: rtl/calc_entry_fsm.sv
// Calculator keypad entry and sequencing FSM: builds BCD operands from key
// presses, sequences one-cycle ALU evaluation and chains results into operand 0.
module calc_entry_fsm #(
  parameter int DIGIT_NUM = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_valid,
  input  logic [4:0]             key_code,
  output logic                   key_ready,
  output logic                   operand0_sign,
  output logic [DIGIT_NUM*4-1:0] operand0,
  output logic [2:0]             operand0_dp,
  output logic                   operand1_sign,
  output logic [DIGIT_NUM*4-1:0] operand1,
  output logic [2:0]             operand1_dp,
  output logic [2:0]             operation,
  input  logic [DIGIT_NUM*4-1:0] result,
  input  logic                   result_sign,
  input  logic [2:0]             result_dp,
  output logic [DIGIT_NUM*4-1:0] disp_value,
  output logic                   disp_sign,
  output logic [2:0]             disp_dp,
  output logic                   error
);
  localparam int W  = DIGIT_NUM*4;
  localparam int CW = $clog2(DIGIT_NUM+1);

  typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, EVAL, RESULT, ERR} state_t;

  typedef struct packed {
    logic          sign;
    logic [W-1:0]  val;
    logic [2:0]    dp;
    logic          dpm;
    logic [CW-1:0] cnt;
  } entry_t;

  localparam entry_t ENT_CLR = '0;

  state_t     state_q, state_d;
  entry_t     a_q, a_d, b_q, b_d;
  logic [2:0] op_q, op_d, pend_q, pend_d;
  logic       chain_q, chain_d;
  logic       accept, k_ent, k_op, k_eq, k_ce, k_ac, k_neg;
  logic [2:0] k_opc;

  // Digit, '.' and '+/-' edits applied to one entry register.
  function automatic entry_t ent_key(entry_t e, logic [4:0] k);
    entry_t r;
    r = e;
    if (k <= 5'd9) begin
      if (!(e.val == '0 && !e.dpm && k == 5'd0) && e.cnt != CW'(DIGIT_NUM) &&
          !(e.dpm && e.dp == 3'd7)) begin
        r.val = {e.val[W-5:0], k[3:0]};
        r.cnt = e.cnt + CW'(1);
        if (e.dpm) r.dp = e.dp + 3'd1;
      end
    end else if (k == 5'd10) begin
      r.dpm = 1'b1;
    end else if (k == 5'd19) begin
      r.sign = ~e.sign;
    end
    return r;
  endfunction

  assign key_ready = (state_q != EVAL);
  assign accept    = key_valid && key_ready;
  assign k_ent     = (key_code <= 5'd10) || (key_code == 5'd19);
  assign k_op      = (key_code >= 5'd11) && (key_code <= 5'd15);
  assign k_eq      = (key_code == 5'd16);
  assign k_ce      = (key_code == 5'd17);
  assign k_ac      = (key_code == 5'd18);
  assign k_neg     = (key_code == 5'd19);
  assign k_opc     = 3'(key_code - 5'd11);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    pend_d  = pend_q;
    chain_d = chain_q;
    if (state_q == EVAL) begin
      // Divide by zero ignores sign and dp of the divisor.
      if (op_q == 3'd3 && b_q.val == '0) begin
        state_d = ERR;
      end else begin
        a_d      = ENT_CLR;
        a_d.val  = result;
        a_d.sign = result_sign;
        a_d.dp   = (op_q <= 3'd2) ? result_dp : 3'd0;
        if (chain_q) begin
          op_d    = pend_q;
          state_d = OP_WAIT;
        end else begin
          state_d = RESULT;
        end
      end
    end else if (accept) begin
      if (k_ac || (state_q == ERR && k_ce)) begin
        a_d     = ENT_CLR;
        b_d     = ENT_CLR;
        op_d    = 3'd0;
        pend_d  = 3'd0;
        chain_d = 1'b0;
        state_d = ENTER_A;
      end else begin
        case (state_q)
          ENTER_A: begin
            if (k_ent) a_d = ent_key(a_q, key_code);
            else if (k_ce) a_d = ENT_CLR;
            else if (k_op) begin
              op_d    = k_opc;
              state_d = OP_WAIT;
            end
          end
          OP_WAIT: begin
            if (k_op) op_d = k_opc;
            else if (k_ent) begin
              b_d     = ent_key(ENT_CLR, key_code);
              state_d = ENTER_B;
            end
          end
          ENTER_B: begin
            if (k_ent) b_d = ent_key(b_q, key_code);
            else if (k_ce) b_d = ENT_CLR;
            else if (k_op) begin
              pend_d  = k_opc;
              chain_d = 1'b1;
              state_d = EVAL;
            end else if (k_eq) begin
              chain_d = 1'b0;
              state_d = EVAL;
            end
          end
          RESULT: begin
            if (k_neg) a_d.sign = ~a_q.sign;
            else if (k_ent) begin
              a_d     = ent_key(ENT_CLR, key_code);
              state_d = ENTER_A;
            end else if (k_op) begin
              op_d    = k_opc;
              state_d = OP_WAIT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
      a_q     <= ENT_CLR;
      b_q     <= ENT_CLR;
      op_q    <= 3'd0;
      pend_q  <= 3'd0;
      chain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      chain_q <= chain_d;
    end
  end

  assign operand0_sign = a_q.sign;
  assign operand0      = a_q.val;
  assign operand0_dp   = a_q.dp;
  assign operand1_sign = b_q.sign;
  assign operand1      = b_q.val;
  assign operand1_dp   = b_q.dp;
  assign operation     = op_q;
  assign error         = (state_q == ERR);

  always_comb begin
    disp_value = a_q.val;
    disp_sign  = a_q.sign;
    disp_dp    = a_q.dp;
    case (state_q)
      ENTER_B, EVAL: begin
        disp_value = b_q.val;
        disp_sign  = b_q.sign;
        disp_dp    = b_q.dp;
      end
      ERR: begin
        disp_value = {DIGIT_NUM{4'h9}};
        disp_sign  = 1'b0;
        disp_dp    = 3'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: directed key sequences then random keys, checked
// against a digit-list reference model and an integer-arithmetic ALU stand-in.
module tb_calc_entry_fsm;
  localparam int N = 8;
  localparam int M_A = 0, M_OPW = 1, M_B = 2, M_EVAL = 3, M_RES = 4, M_ERR = 5;

  logic        clk = 1'b0, rst_n = 1'b0, key_valid = 1'b0;
  logic [4:0]  key_code = 5'd0;
  logic        key_ready, operand0_sign, operand1_sign, result_sign, disp_sign, error;
  logic [31:0] operand0, operand1, result, disp_value;
  logic [2:0]  operand0_dp, operand1_dp, operation, result_dp, disp_dp;
  logic [35:0] alu_out;

  calc_entry_fsm #(.DIGIT_NUM(N)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready),
    .operand0_sign(operand0_sign), .operand0(operand0), .operand0_dp(operand0_dp),
    .operand1_sign(operand1_sign), .operand1(operand1), .operand1_dp(operand1_dp),
    .operation(operation), .result(result), .result_sign(result_sign),
    .result_dp(result_dp), .disp_value(disp_value), .disp_sign(disp_sign),
    .disp_dp(disp_dp), .error(error)
  );

  always #5 clk = ~clk;

  function automatic longint bcd2int(input logic [31:0] v);
    longint r;
    r = 0;
    for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input longint m);
    logic [31:0] r;
    longint x;
    r = '0;
    x = m % 100000000;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // ALU stand-in: signed integer arithmetic, result dp copied from operand 0.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic as, input logic [2:0] adp,
                                         input logic [31:0] b, input logic bs, input logic [2:0] op);
    longint x, y, r;
    x = as ? -bcd2int(a) : bcd2int(a);
    y = bs ? -bcd2int(b) : bcd2int(b);
    case (op)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x * y;
      3'd3: r = (y == 0) ? 0 : x / y;
      3'd4: begin
        r = 1;
        for (int i = 0; i < int'((y < 0 ? -y : y) % 8); i++) r = (r * x) % 100000000;
      end
      default: r = 0;
    endcase
    return {(r < 0), adp, int2bcd(r < 0 ? -r : r)};
  endfunction

  always_comb alu_out = alu_fn(operand0, operand0_sign, operand0_dp, operand1, operand1_sign, operation);
  assign result      = alu_out[31:0];
  assign result_dp   = alu_out[34:32];
  assign result_sign = alu_out[35];

  // Reference model: each entry is a list of typed digits plus point/sign flags.
  int mode, m_op, m_pend;
  bit m_chain;
  int dg[2][8];
  int n[2], dp[2];
  bit dpm[2], sg[2];
  int nassert = 0, nfail = 0;

  function automatic logic [31:0] mval(input int e);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n[e]; i++) v = (v << 4) | 32'(dg[e][i]);
    return v;
  endfunction

  task automatic clr(input int e);
    n[e] = 0; dp[e] = 0; dpm[e] = 0; sg[e] = 0;
  endtask

  task automatic m_reset();
    clr(0); clr(1);
    m_op = 0; m_pend = 0; m_chain = 0; mode = M_A;
  endtask

  task automatic m_ent(input int e, input int k);
    if (k <= 9) begin
      if (mval(e) == 0 && !dpm[e] && k == 0) begin
        // leading zero: nothing to record
      end else if (n[e] < N && !(dpm[e] && dp[e] == 7)) begin
        dg[e][n[e]] = k;
        n[e]++;
        if (dpm[e]) dp[e]++;
      end
    end else if (k == 10) dpm[e] = 1;
    else if (k == 19) sg[e] = !sg[e];
  endtask

  task automatic m_key(input int k);
    bit ent, isop;
    ent  = (k <= 10) || (k == 19);
    isop = (k >= 11) && (k <= 15);
    if (k == 18) m_reset();
    else if (mode == M_ERR) begin
      if (k == 17) m_reset();
    end else if (mode == M_A) begin
      if (ent) m_ent(0, k);
      else if (k == 17) clr(0);
      else if (isop) begin m_op = k - 11; mode = M_OPW; end
    end else if (mode == M_OPW) begin
      if (isop) m_op = k - 11;
      else if (ent) begin clr(1); m_ent(1, k); mode = M_B; end
    end else if (mode == M_B) begin
      if (ent) m_ent(1, k);
      else if (k == 17) clr(1);
      else if (isop) begin m_pend = k - 11; m_chain = 1; mode = M_EVAL; end
      else if (k == 16) begin m_chain = 0; mode = M_EVAL; end
    end else if (mode == M_RES) begin
      if (k == 19) sg[0] = !sg[0];
      else if (ent) begin clr(0); m_ent(0, k); mode = M_A; end
      else if (isop) begin m_op = k - 11; mode = M_OPW; end
    end
  endtask

  task automatic m_eval();
    logic [35:0] r;
    if (m_op == 3 && mval(1) == 0) mode = M_ERR;
    else begin
      r = alu_fn(mval(0), sg[0], 3'(dp[0]), mval(1), sg[1], 3'(m_op));
      n[0] = 8;
      for (int i = 0; i < 8; i++) dg[0][i] = int'(r[(7-i)*4 +: 4]);
      sg[0]  = r[35];
      dp[0]  = (m_op <= 2) ? int'(r[34:32]) : 0;
      dpm[0] = 0;
      if (m_chain) begin m_op = m_pend; mode = M_OPW; end
      else mode = M_RES;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int e;
    chk({tag, " key_ready"}, 32'(key_ready), 32'(mode != M_EVAL));
    chk({tag, " error"}, 32'(error), 32'(mode == M_ERR));
    chk({tag, " operand0"}, operand0, mval(0));
    chk({tag, " operand0_sign"}, 32'(operand0_sign), 32'(sg[0]));
    chk({tag, " operand0_dp"}, 32'(operand0_dp), 32'(dp[0]));
    chk({tag, " operand1"}, operand1, mval(1));
    chk({tag, " operand1_sign"}, 32'(operand1_sign), 32'(sg[1]));
    chk({tag, " operand1_dp"}, 32'(operand1_dp), 32'(dp[1]));
    chk({tag, " operation"}, 32'(operation), 32'(m_op));
    if (mode == M_ERR) begin
      chk({tag, " disp_value"}, disp_value, 32'h99999999);
      chk({tag, " disp_sign"}, 32'(disp_sign), 32'd0);
      chk({tag, " disp_dp"}, 32'(disp_dp), 32'd0);
    end else if (mode != M_EVAL) begin
      e = (mode == M_B) ? 1 : 0;
      chk({tag, " disp_value"}, disp_value, mval(e));
      chk({tag, " disp_sign"}, 32'(disp_sign), 32'(sg[e]));
      chk({tag, " disp_dp"}, 32'(disp_dp), 32'(dp[e]));
    end
  endtask

  task automatic press(input int k);
    bit rdy;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 5'(k);
    rdy = (mode != M_EVAL);
    chk($sformatf("key %0d ready", k), 32'(key_ready), 32'(rdy));
    @(posedge clk);
    #1 key_valid = 1'b0;
    if (rdy) m_key(k);
    check_all($sformatf("after key %0d", k));
    if (mode == M_EVAL) begin
      // a key offered during EVAL (often AC) must be dropped
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = ($urandom_range(0, 1) == 0) ? 5'd18 : 5'($urandom_range(0, 31));
      @(posedge clk);
      #1 key_valid = 1'b0;
      m_eval();
      check_all("after eval");
    end
  endtask

  function automatic int rand_key();
    int r;
    r = $urandom_range(0, 99);
    if (r < 50) return $urandom_range(0, 9);
    if (r < 55) return 10;
    if (r < 70) return $urandom_range(11, 15);
    if (r < 78) return 16;
    if (r < 82) return 17;
    if (r < 85) return 18;
    if (r < 90) return 19;
    return $urandom_range(20, 31);
  endfunction

  initial begin
    m_reset();
    #12 rst_n = 1'b1;
    @(negedge clk);
    check_all("reset");

    press(1); press(2); press(10); press(5);
    chk("entry disp_value", disp_value, 32'h00000125);
    chk("entry disp_dp", 32'(disp_dp), 32'd1);

    press(18); press(3); press(11); press(4); press(16);
    chk("add result", disp_value, 32'h00000007);
    chk("add ready back", 32'(key_ready), 32'd1);

    press(18);
    for (int i = 0; i < 9; i++) press(9);
    chk("nine digits", disp_value, 32'h99999999);
    press(18); press(0); press(0);
    chk("leading zeros", disp_value, 32'h0);
    press(10); press(10); press(5);
    chk("double point dp", 32'(disp_dp), 32'd1);

    press(18); press(8); press(14); press(0); press(16);
    chk("div0 error", 32'(error), 32'd1);
    chk("div0 disp", disp_value, 32'h99999999);
    press(5);
    chk("err digit ignored", disp_value, 32'h99999999);
    press(17);
    chk("ce clears error", 32'(error), 32'd0);
    chk("ce clears disp", disp_value, 32'h0);

    press(18); press(2); press(13); press(3); press(12);
    chk("chain operand0", operand0, 32'h6);
    chk("chain operation", 32'(operation), 32'd1);
    press(1); press(16);
    chk("chain result", disp_value, 32'h5);

    press(18); press(1); press(10); press(5); press(14); press(3); press(16);
    chk("div dp forced 0", 32'(disp_dp), 32'd0);
    press(18); press(1); press(10); press(5); press(13); press(3); press(16);
    chk("mul dp kept", 32'(disp_dp), 32'd1);

    press(18); press(10);
    for (int i = 0; i < 8; i++) press(1);
    chk("dp limit", 32'(disp_dp), 32'd7);
    chk("dp limit value", disp_value, 32'h01111111);

    // asynchronous reset landing inside EVAL
    press(18); press(4); press(11); press(5);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 5'd16;
    @(posedge clk);
    #1 key_valid = 1'b0;
    chk("eval before reset", 32'(key_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst operand0", operand0, 32'h0);
    chk("rst operand1", operand1, 32'h0);
    chk("rst disp", disp_value, 32'h0);
    chk("rst ready", 32'(key_ready), 32'd1);
    #3 rst_n = 1'b1;
    m_reset();
    @(negedge clk);
    check_all("post reset");

    for (int i = 0; i < 400; i++) press(rand_key());

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
- Keypad-entry and sequencing stage that sits directly upstream of the calculator ALU.
- Turns decoded key presses into the ALU's BCD operand, sign, decimal-point and operation inputs.
- Sequences evaluation, captures the ALU result into an accumulator, and drives the value/sign/dp shown on the display.
- Supports operator chaining: the result becomes operand 0 of the next operation.

Parameters:
- DIGIT_NUM, 8, number of BCD digits per operand (operand width = DIGIT_NUM*4).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe; key_code is valid in the same cycle.
- key_code  in  5  key codes:
  - 0-9 digit
  - 10 '.'
  - 11 '+', 12 '-', 13 '*', 14 '/', 15 '^'
  - 16 '='
  - 17 CE (clear entry)
  - 18 AC (all clear)
  - 19 '+/-'
  - 20-31 ignored
- key_ready  out  1  high when a key will be accepted.
- operand0_sign, operand0, operand0_dp  out  1, DIGIT_NUM*4, 3  ALU operand 0 (accumulator or entry A).
- operand1_sign, operand1, operand1_dp  out  1, DIGIT_NUM*4, 3  ALU operand 1 (entry B).
- operation  out  3  op encoding: 0 add, 1 sub, 2 mul, 3 div, 4 pow.
- result, result_sign, result_dp  in  DIGIT_NUM*4, 1, 3  combinational ALU outputs.
- disp_value, disp_sign, disp_dp  out  DIGIT_NUM*4, 1, 3  value to display.
- error  out  1  high in the ERR state.

Behaviour:
- Reset: every output register is 0; state is ENTER_A; key_ready is 1.
- States:
  - ENTER_A: editing operand 0; display shows A.
  - OP_WAIT: operator latched; display shows A.
  - ENTER_B: editing operand 1; display shows B.
  - EVAL: one cycle; operands are frozen and key_ready is 0.
  - RESULT: display shows the accumulator held in operand 0.
  - ERR: display shows all 9s with sign 0; error is 1.
- Latency:
  - A key accepted at edge n updates registers and display at edge n+1.
  - '=' or a chained operator moves to EVAL at n+1; the result is captured into operand0 at n+2.
- Keys arriving while key_ready is 0 are dropped without side effect.
- Digit entry, for the active entry E (A in ENTER_A, B in ENTER_B):
  - If E is 0, E has no dp, and the digit is 0: no change.
  - Otherwise, if digit count < DIGIT_NUM: shift E left 4 and insert the digit in bits [3:0]. If dp mode is active, increment dp.
  - The digit is ignored if count = DIGIT_NUM, or if dp = 7 with dp mode active.
- Decimal point:
  - '.' enables dp mode once; a repeated '.' is ignored.
  - dp mode with no digits after the point leaves dp at 0.
- Sign: '+/-' toggles the sign of E. In RESULT it toggles the accumulator sign.
- Operator key:
  - In ENTER_A or RESULT: latch operation, go to OP_WAIT.
  - In OP_WAIT: replace operation.
  - In ENTER_B: go to EVAL with the new operator held pending; after capture, go to OP_WAIT with operation set to the pending operator.
- Entering B from OP_WAIT: a digit, '.' or '+/-' clears B and its sign/dp, then applies the key; state becomes ENTER_B.
- '=' key:
  - In ENTER_B: go to EVAL, then RESULT.
  - In ENTER_A, OP_WAIT or RESULT: no effect.
- Digit or '.' in RESULT: clears A and starts a fresh entry; state becomes ENTER_A.
- EVAL capture:
  - operand0 <= result and operand0_sign <= result_sign.
  - operand0_dp <= result_dp for ops 0-2; operand0_dp <= 0 for ops 3-4.
  - Divide by zero (operation 3 and operand1 equal to 0, regardless of sign and dp) goes to ERR instead.
- ERR: only CE or AC is accepted; both go to ENTER_A with everything cleared.
- CE:
  - In ENTER_B: clears B and stays in ENTER_B.
  - In ENTER_A: clears A.
  - In RESULT or OP_WAIT: no effect.
- AC: clears all registers and goes to ENTER_A from any state except EVAL, where keys are dropped.
- Reset asserted mid-EVAL aborts evaluation: nothing is captured and all outputs return to reset values.
- Operands and operation hold steady whenever no key is being accepted.

Test Plan:
- Reset, then keys 1,2,'.',5 -> disp_value=0x00000125, disp_dp=1, disp_sign=0, state ENTER_A.
- Keys 3,'+',4,'=' with the ALU model returning 7 -> key_ready low for exactly one cycle; at edge n+2, disp_value=0x00000007, state RESULT.
- Keys 9 x 9 -> disp_value=0x99999999 and the ninth digit is dropped; a leading 0,0 press leaves 0; a second '.' does not change dp.
- Keys 8,'/',0,'=' -> error=1, disp_value=0x99999999; digit keys ignored; CE -> error=0, all outputs 0.
- Chain keys 2,'*',3,'-' -> after EVAL, operand0=0x6, operation=1, state OP_WAIT; then 1,'=' -> result captured.
- Assert rst_n low for a few ns during EVAL (asynchronous, not aligned to clk) -> all outputs 0 immediately, operand0 not overwritten after release.
